// File: rtl/ibex_instr_stim_seq.sv
// Loadable instruction stimulus sequencer: plays a small program RAM over a valid/ready
// stream in one-shot, loop or single-step mode and counts illegal-instruction responses.
module ibex_instr_stim_seq #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IW    = 32,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_valid_i,
  input  logic [AW-1:0]    load_addr_i,
  input  logic [IW-1:0]    load_data_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [1:0]       mode_i,
  input  logic [AW:0]      len_i,
  input  logic [CNT_W-1:0] loops_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [IW-1:0]    instr_rdata_o,
  output logic             instr_first_cycle_o,
  output logic [AW-1:0]    instr_idx_o,
  input  logic             illegal_insn_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] loop_cnt_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  localparam logic [1:0] ModeLoop = 2'd1;
  localparam logic [1:0] ModeStep = 2'd2;

  state_e           state_q;
  logic [AW-1:0]    ptr_q;
  logic [CNT_W-1:0] loop_cnt_q;
  logic [CNT_W-1:0] illegal_cnt_q;
  logic [1:0]       mode_q;
  logic [AW:0]      len_q;
  logic [CNT_W-1:0] loops_q;
  logic             first_q;
  logic             done_q;

  logic [IW-1:0]    mem_q [DEPTH];

  logic             last_entry;
  logic [CNT_W:0]   loop_next;
  logic             more_passes;

  always_comb begin
    last_entry  = ({1'b0, ptr_q} == (len_q - (AW + 1)'(1)));
    loop_next   = {1'b0, loop_cnt_q} + (CNT_W + 1)'(1);
    // loops==0 means run forever; otherwise stop once loop_next reaches loops
    more_passes = (mode_q == ModeLoop) &&
                  ((loops_q == '0) || (loop_next < {1'b0, loops_q}));
  end

  // Program RAM is not reset so a program survives a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (load_valid_i && (state_q == StIdle)) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      loop_cnt_q    <= '0;
      illegal_cnt_q <= '0;
      mode_q        <= '0;
      len_q         <= '0;
      loops_q       <= '0;
      first_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop_i) begin
        state_q <= StIdle;
        ptr_q   <= '0;
        first_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (start_i) begin
              mode_q        <= mode_i;
              len_q         <= len_i;
              loops_q       <= loops_i;
              ptr_q         <= '0;
              loop_cnt_q    <= '0;
              illegal_cnt_q <= '0;
              first_q       <= 1'b1;
              if (len_i == '0) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q <= StRun;
              end
            end
          end
          StRun: begin
            // Every transfer presents a fresh entry; a stall does not.
            first_q <= instr_ready_i;
            if (instr_ready_i) begin
              if (illegal_insn_i && (illegal_cnt_q != '1)) begin
                illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
              end
              if (!last_entry) begin
                ptr_q <= ptr_q + AW'(1);
                if (mode_q == ModeStep) begin
                  state_q <= StPause;
                end
              end else begin
                loop_cnt_q <= loop_next[CNT_W-1:0];
                if (more_passes) begin
                  ptr_q <= '0;
                end else begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                end
              end
            end
          end
          StPause: begin
            if (start_i) begin
              state_q <= StRun;
              first_q <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign instr_valid_o       = (state_q == StRun);
  assign instr_first_cycle_o = (state_q == StRun) && first_q;
  assign instr_rdata_o       = mem_q[ptr_q];
  assign instr_idx_o         = ptr_q;
  assign busy_o              = (state_q == StRun) || (state_q == StPause);
  assign done_o              = done_q;
  assign loop_cnt_o          = loop_cnt_q;
  assign illegal_cnt_o       = illegal_cnt_q;

endmodule

// File: tb/tb_ibex_instr_stim_seq.sv
// Bench for ibex_instr_stim_seq: directed scenarios plus random traffic, all checked
// against a queue-based model of the expected instruction stream.
module tb_ibex_instr_stim_seq;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IW    = 32;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned AW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_valid = 1'b0;
  logic [AW-1:0]    load_addr = '0;
  logic [IW-1:0]    load_data = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [1:0]       mode = '0;
  logic [AW:0]      len = '0;
  logic [CNT_W-1:0] loops = '0;
  logic             ready = 1'b0;
  logic             illegal = 1'b0;

  logic             instr_valid;
  logic [IW-1:0]    instr_rdata;
  logic             instr_first;
  logic [AW-1:0]    instr_idx;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] loop_cnt;
  logic [CNT_W-1:0] illegal_cnt;

  ibex_instr_stim_seq #(
    .DEPTH(DEPTH),
    .IW   (IW),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .load_valid_i       (load_valid),
    .load_addr_i        (load_addr),
    .load_data_i        (load_data),
    .start_i            (start),
    .stop_i             (stop),
    .mode_i             (mode),
    .len_i              (len),
    .loops_i            (loops),
    .instr_valid_o      (instr_valid),
    .instr_ready_i      (ready),
    .instr_rdata_o      (instr_rdata),
    .instr_first_cycle_o(instr_first),
    .instr_idx_o        (instr_idx),
    .illegal_insn_i     (illegal),
    .busy_o             (busy),
    .done_o             (done),
    .loop_cnt_o         (loop_cnt),
    .illegal_cnt_o      (illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: the stream still owed to the consumer, as a queue of RAM indices.
  logic [IW-1:0] m_mem [DEPTH];
  bit            m_wr [DEPTH];
  int            m_q[$];
  bit            m_active, m_paused, m_finished, m_infinite, m_stalled, m_done;
  int            m_loops_done, m_ill, m_len, m_mode;

  task automatic model_clear();
    m_q.delete();
    m_active   = 0;
    m_paused   = 0;
    m_finished = 0;
    m_infinite = 0;
    m_stalled  = 0;
    m_done     = 0;
  endtask

  task automatic push_pass();
    for (int i = 0; i < m_len; i++) m_q.push_back(i);
  endtask

  task automatic compare_outputs();
    bit exp_valid;
    exp_valid = m_active && !m_paused;
    check_eq("valid", 64'(instr_valid), 64'(exp_valid));
    check_eq("busy", 64'(busy), 64'(m_active));
    check_eq("done", 64'(done), 64'(m_done));
    check_eq("loop_cnt", 64'(loop_cnt), 64'(m_loops_done));
    check_eq("illegal_cnt", 64'(illegal_cnt), 64'(m_ill));
    if (exp_valid && m_q.size() > 0) begin
      check_eq("rdata", 64'(instr_rdata), 64'(m_mem[m_q[0]]));
      check_eq("idx", 64'(instr_idx), 64'(m_q[0]));
      check_eq("first", 64'(instr_first), 64'(!m_stalled));
    end else begin
      check_eq("first_idle", 64'(instr_first), 64'd0);
    end
  endtask

  // Advance one clock: update the model from the driven inputs, then compare.
  task automatic tick();
    bit run_now;
    int idx;
    run_now   = m_active && !m_paused;
    m_done    = 0;
    m_stalled = run_now && !ready && !stop;
    if (load_valid && !m_active && !m_finished) begin
      m_mem[load_addr] = load_data;
      m_wr[load_addr]  = 1;
    end
    if (stop) begin
      model_clear();
    end else if (!m_active) begin
      if (start) begin
        m_finished   = 0;
        m_loops_done = 0;
        m_ill        = 0;
        m_len        = int'(len);
        m_mode       = int'(mode);
        m_q.delete();
        m_infinite   = 0;
        if (m_len == 0) begin
          m_finished = 1;
          m_done     = 1;
        end else begin
          m_active = 1;
          if (m_mode == 1 && loops == 0) begin
            m_infinite = 1;
            push_pass();
          end else if (m_mode == 1) begin
            for (int p = 0; p < int'(loops); p++) push_pass();
          end else begin
            push_pass();
          end
        end
      end
    end else if (m_paused) begin
      if (start) m_paused = 0;
    end else if (ready) begin
      idx = m_q.pop_front();
      if (illegal && m_ill < 255) m_ill++;
      if (idx == m_len - 1) m_loops_done = (m_loops_done + 1) % 256;
      if (m_q.size() == 0) begin
        if (m_infinite) begin
          push_pass();
        end else begin
          m_active   = 0;
          m_finished = 1;
          m_done     = 1;
        end
      end else if (m_mode == 2) begin
        m_paused = 1;
      end
    end
    @(posedge clk);
    #1;
    compare_outputs();
    start      = 1'b0;
    stop       = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_eq("rst_valid", 64'(instr_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_idx", 64'(instr_idx), 64'd0);
    check_eq("rst_loop_cnt", 64'(loop_cnt), 64'd0);
    check_eq("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
    if (m_wr[0]) check_eq("rst_rdata", 64'(instr_rdata), 64'(m_mem[0]));
    model_clear();
    m_loops_done = 0;
    m_ill        = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load(input int addr, input logic [IW-1:0] data);
    load_valid = 1'b1;
    load_addr  = AW'(addr);
    load_data  = data;
    tick();
  endtask

  task automatic start_run(input int md, input int ln, input int lp);
    mode  = 2'(md);
    len   = (AW + 1)'(ln);
    loops = CNT_W'(lp);
    start = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
    m_loops_done = 0;
    m_ill        = 0;
    m_len        = 0;
    m_mode       = 0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // 1: one-shot SUB/AND program
    load(0, 32'h403100B3);
    load(1, 32'h0062F233);
    ready = 1'b1;
    start_run(0, 2, 0);
    check_eq("t1_rdata_sub", 64'(instr_rdata), 64'h403100B3);
    tick();
    check_eq("t1_rdata_and", 64'(instr_rdata), 64'h0062F233);
    tick();
    check_eq("t1_done", 64'(done), 64'd1);
    check_eq("t1_loop_cnt", 64'(loop_cnt), 64'd1);
    tick();

    // 2: stall on entry 0
    ready = 1'b0;
    start_run(0, 2, 0);
    for (int i = 0; i < 3; i++) tick();
    check_eq("t2_held", 64'(instr_rdata), 64'h403100B3);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // 3: three loop passes, no bubble at wrap
    start_run(1, 2, 3);
    for (int i = 0; i < 6; i++) tick();
    check_eq("t3_loop_cnt", 64'(loop_cnt), 64'd3);
    tick();

    // 4: single step
    start_run(2, 2, 0);
    tick();
    tick();
    check_eq("t4_paused", 64'(instr_valid), 64'd0);
    start = 1'b1;
    tick();
    tick();
    tick();

    // 5: saturating illegal counter in an endless loop
    illegal = 1'b1;
    start_run(1, 2, 0);
    for (int i = 0; i < 300; i++) tick();
    check_eq("t5_sat", 64'(illegal_cnt), 64'd255);
    illegal = 1'b0;

    // 6: load during RUN ignored, stop aborts, len=0 finishes at once
    load(0, 32'hDEADBEEF);
    stop = 1'b1;
    tick();
    check_eq("t6_ram_kept", 64'(instr_rdata), 64'h403100B3);
    start_run(0, 0, 0);
    check_eq("t6_len0_done", 64'(done), 64'd1);
    tick();

    // async reset mid-run keeps RAM
    start_run(1, 2, 0);
    tick();
    do_reset();
    tick();

    // random traffic
    for (int i = 0; i < DEPTH; i++) load(i, $urandom());
    for (int c = 0; c < 3000; c++) begin
      ready   = ($urandom_range(0, 3) != 0);
      illegal = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) stop = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b1;
        mode  = 2'($urandom_range(0, 3));
        len   = (AW + 1)'($urandom_range(0, DEPTH));
        loops = CNT_W'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 5) == 0) begin
        load_valid = 1'b1;
        load_addr  = AW'($urandom_range(0, DEPTH - 1));
        load_data  = $urandom();
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
